pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Downstream companion of the clock-generation PLL. Drives the PLL reset, qualifies its async
//  'locked' flag, then releases per-domain resets in a staggered order once lock is stable.
//  Re-arms the PLL on lock timeout and on lock loss. Runs on the 50 MHz board reference clock.
// PARAMETERS
//  NUM_DOMAINS          3       number of downstream reset outputs (one per PLL outclk)
//  PLL_RST_CYCLES       16      refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES   1024    consecutive locked_sync=1 edges required before release (>=1)
//  LOCK_TIMEOUT_CYCLES  500000  edges in WAIT_LOCK without lock before PLL re-reset (10 ms)
//  STAGGER_CYCLES       8       edges between successive domain_rst releases (>=1)
//  Counter width: localparam CW = $clog2(max of cycle params + 1); shared timer, no overflow.
// PORTS
//  refclk           in   1            50 MHz reference clock; sole clock
//  rst              in   1            asynchronous, active-high reset
//  locked           in   1            PLL lock flag, asynchronous to refclk
//  pll_rst          out  1            reset to PLL, active-high
//  domain_rst       out  NUM_DOMAINS  per-domain reset, active-high, refclk-registered
//  ready            out  1            all domains released, lock stable
//  lock_loss_count  out  8            (LOCK_LOSS_CNT_EN only) saturating lock-loss count
// BEHAVIOUR
//  - Reset values: pll_rst=1, domain_rst=all 1, ready=0, state=PLL_RST, timer=0,
//    sync flops=0, lock_loss_count=0. All outputs registered; no combinational outputs.
//  - locked passes a 2-flop synchronizer -> locked_sync (2-edge latency). Downstream
//    domains re-synchronize domain_rst deassertion locally (outside this block).
//  - FSM:
//    PLL_RST : pll_rst=1; after PLL_RST_CYCLES edges -> WAIT_LOCK, pll_rst=0 on that edge.
//    WAIT_LOCK: timer counts edges with locked_sync=0; reaching LOCK_TIMEOUT_CYCLES ->
//               PLL_RST. Edge with locked_sync=1 -> STABLE, stable count=1.
//    STABLE  : each edge with locked_sync=1 increments count; on the edge count reaches
//              LOCK_STABLE_CYCLES -> RELEASE and domain_rst[0] cleared on that same edge.
//              locked_sync=0 -> WAIT_LOCK, timeout timer restarts at 0.
//    RELEASE : domain_rst[i] clears on edge i*STAGGER_CYCLES after entry (domain 0 at entry).
//              Edge after last domain clears -> RUN, ready=1.
//    RUN     : hold. Stay until lock loss.
//  - Lock loss (locked_sync=0 in RELEASE or RUN): on that edge all domain_rst=1, ready=0,
//    state=PLL_RST, pll_rst=1; release order restarts from domain 0.
//  - Domains never released out of order; once set by lock loss, domain_rst stays 1 until
//    next full RELEASE.
//  - rst mid-operation: immediate async return to reset values regardless of state.
//  - Lock glitch of a single edge during STABLE fully restarts the stability count.
// CONFIGURATION
//  LOCK_LOSS_CNT_EN defined: port lock_loss_count present; +1 per lock-loss event
//    (RELEASE/RUN only, not WAIT_LOCK timeouts), saturates at 255, cleared only by rst.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING  (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=50, STAGGER=2, N=3)
//  1 rst pulse, locked=0 -> pll_rst=1 for 4 edges after rst falls, then 0; domain_rst=3'b111.
//  2 locked rises, edge1 = first edge sampling it -> domain_rst[0]=0 after edge 10,
//    [1] after 12, [2] after 14, ready=1 after edge 15.
//  3 locked never rises -> pll_rst re-asserts 50 edges after falling, 4 edges high, repeats.
//  4 locked drops 1 cycle at stable count 5 -> release delayed; full 8-edge count restarts.
//  5 in RUN, locked=0 -> 3 edges later (2 sync + 1) domain_rst=3'b111, ready=0, pll_rst=1;
//    with LOCK_LOSS_CNT_EN lock_loss_count 0->1; 300 losses -> holds 255.
//  6 rst asserted mid-RELEASE (domain 0 released) -> outputs at reset values same cycle.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives pll_rst, qualifies the asynchronous PLL lock flag, and releases per-domain resets in a staggered order.
// Optional build macro LOCK_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter on port lock_loss_count.
module pll_reset_sequencer #(
   parameter int NUM_DOMAINS         = 3,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 500000,
   parameter int STAGGER_CYCLES      = 8
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   locked,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   ready
`ifdef LOCK_LOSS_CNT_EN
   ,
   output logic [7:0]             lock_loss_count
`endif
);

   function automatic int maxOf4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   localparam int MAXCYC = maxOf4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES, STAGGER_CYCLES);
   localparam int CW = $clog2(MAXCYC + 1);
   localparam int IW = $clog2(NUM_DOMAINS + 1);

   localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DOMAINS);

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   state_t                 state_q;
   logic [CW-1:0]          timer_q;
   logic [IW-1:0]          relIdx_q;
   logic                   pllRst_q;
   logic [NUM_DOMAINS-1:0] domainRst_q;
   logic                   ready_q;
   logic                   lockedMeta_q;
   logic                   lockedSync_q;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lockedMeta_q <= 1'b0;
         lockedSync_q <= 1'b0;
      end else begin
         lockedMeta_q <= locked;
         lockedSync_q <= lockedMeta_q;
      end
   end

   // One shared timer: PLL reset hold, lock timeout, stability count, release stagger.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q     <= PLL_RST;
         timer_q     <= '0;
         relIdx_q    <= '0;
         pllRst_q    <= 1'b1;
         domainRst_q <= '1;
         ready_q     <= 1'b0;
      end else begin
         case (state_q)
            PLL_RST: begin
               if (timer_q == PLL_RST_LAST) begin
                  state_q  <= WAIT_LOCK;
                  pllRst_q <= 1'b0;
                  timer_q  <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lockedSync_q) begin
                  if (LOCK_STABLE_CYCLES == 1) begin
                     state_q        <= RELEASE;
                     domainRst_q[0] <= 1'b0;
                     relIdx_q       <= IW'(1);
                     timer_q        <= '0;
                  end else begin
                     state_q <= STABLE;
                     timer_q <= CW'(1);
                  end
               end else if (timer_q == TIMEOUT_LAST) begin
                  state_q  <= PLL_RST;
                  pllRst_q <= 1'b1;
                  timer_q  <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            STABLE: begin
               if (!lockedSync_q) begin
                  state_q <= WAIT_LOCK;
                  timer_q <= '0;
               end else if (timer_q == STABLE_LAST) begin
                  state_q        <= RELEASE;
                  domainRst_q[0] <= 1'b0;
                  relIdx_q       <= IW'(1);
                  timer_q        <= '0;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            RELEASE, RUN: begin
               // Lock loss puts every domain back into reset and re-arms the PLL.
               if (!lockedSync_q) begin
                  state_q     <= PLL_RST;
                  pllRst_q    <= 1'b1;
                  domainRst_q <= '1;
                  ready_q     <= 1'b0;
                  timer_q     <= '0;
               end else if (state_q == RELEASE) begin
                  if (relIdx_q == LAST_IDX) begin
                     state_q <= RUN;
                     ready_q <= 1'b1;
                  end else if (timer_q == STAGGER_LAST) begin
                     for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (relIdx_q == IW'(i)) domainRst_q[i] <= 1'b0;
                     end
                     relIdx_q <= relIdx_q + 1'b1;
                     timer_q  <= '0;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= PLL_RST;
               pllRst_q    <= 1'b1;
               domainRst_q <= '1;
               ready_q     <= 1'b0;
               timer_q     <= '0;
            end
         endcase
      end
   end

   assign pll_rst    = pllRst_q;
   assign domain_rst = domainRst_q;
   assign ready      = ready_q;

`ifdef LOCK_LOSS_CNT_EN
   logic [7:0] lossCount_q;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lossCount_q <= '0;
      end else if ((state_q == RELEASE || state_q == RUN) && !lockedSync_q &&
                   lossCount_q != 8'hFF) begin
         lossCount_q <= lossCount_q + 1'b1;
      end
   end

   assign lock_loss_count = lossCount_q;
`endif

endmodule
